// File: rtl/deck_pkg.sv
// Shared encodings for the multi-deck beat-position controller.
package deck_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        PLAYING = 2'd1,
        PAUSED  = 2'd2
    } deck_state_t;

    typedef enum logic [1:0] {
        RATE_X1   = 2'b00,
        RATE_X2   = 2'b01,
        RATE_HALF = 2'b10,
        RATE_REV  = 2'b11
    } rate_t;

    typedef enum logic {
        FREE  = 1'b0,
        FIXED = 1'b1
    } mode_t;

endpackage

// File: rtl/deck_channel.sv
// One deck: transport state machine, half-rate phase, position update and wrap detection.
module deck_channel
    import deck_pkg::*;
#(
    parameter int unsigned LEN = 6250000,
    parameter int unsigned W   = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         play_req,
    input  logic         pause_req,
    input  logic         stop_req,
    input  logic         mode,
    input  logic [1:0]   rate,
    input  logic [W-1:0] loop_start,
    input  logic [W-1:0] loop_end,
    input  logic         seek_valid,
    input  logic [W-1:0] seek_pos,
    output logic [W-1:0] ibeat,
    output logic [1:0]   deck_state,
    output logic         wrap_pulse
);

    localparam logic [W:0] LEN_X = (W+1)'(LEN);
    localparam logic [W:0] ONE_X = (W+1)'(1);
    localparam logic [W:0] TWO_X = (W+1)'(2);

    deck_state_t state;
    logic        phase;
    rate_t       rate_sel;
    logic        win_ok;
    logic        advance;
    logic        wrap_n;
    logic [W:0]  pos_x, ls_x, le_x, seek_x, step_x, fwd_x, nxt_x, seek_clamp;

    assign rate_sel   = rate_t'(rate);
    assign deck_state = state;

    // Next position for a playing edge (W+1-bit arithmetic) and clamped seek target
    always_comb begin
        pos_x  = {1'b0, ibeat};
        ls_x   = {1'b0, loop_start};
        le_x   = {1'b0, loop_end};
        seek_x = {1'b0, seek_pos};
        win_ok = (mode_t'(mode) == FIXED) && (ls_x < le_x) && (le_x < LEN_X);

        step_x = '0;
        case (rate_sel)
            RATE_X1:   step_x = ONE_X;
            RATE_X2:   step_x = TWO_X;
            RATE_HALF: step_x = phase ? ONE_X : '0;
            default:   step_x = '0;
        endcase

        fwd_x  = pos_x + step_x;
        nxt_x  = fwd_x;
        wrap_n = 1'b0;
        if (rate_sel == RATE_REV) begin
            // pos >= start && pos-1 < start reduces to pos == start
            if (win_ok && (pos_x == ls_x)) begin
                nxt_x  = le_x;
                wrap_n = 1'b1;
            end else if (pos_x == '0) begin
                nxt_x  = LEN_X - ONE_X;
                wrap_n = 1'b1;
            end else begin
                nxt_x  = pos_x - ONE_X;
            end
        end else if (win_ok && (pos_x <= le_x) && (fwd_x > le_x)) begin
            nxt_x  = ls_x;
            wrap_n = 1'b1;
        end else if (fwd_x >= LEN_X) begin
            nxt_x  = fwd_x - LEN_X;
            wrap_n = 1'b1;
        end

        seek_clamp = (seek_x >= LEN_X) ? (LEN_X - ONE_X) : seek_x;
        advance    = (state == PLAYING) && !seek_valid && !play_req && !pause_req;
    end

    // Transport FSM with prioritised stop/seek/play/pause/advance and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= STOPPED;
            ibeat      <= '0;
            phase      <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            if (stop_req) begin
                state <= STOPPED;
                ibeat <= '0;
                phase <= 1'b0;
            end else begin
                if (seek_valid) begin
                    ibeat <= seek_clamp[W-1:0];
                    phase <= 1'b0;
                end
                if (play_req) begin
                    state <= PLAYING;
                end else if (pause_req) begin
                    case (state)
                        PLAYING: state <= PAUSED;
                        PAUSED:  state <= PLAYING;
                        default: state <= state;
                    endcase
                end
                if (advance) begin
                    ibeat      <= nxt_x[W-1:0];
                    wrap_pulse <= wrap_n;
                    if (rate_sel == RATE_HALF)
                        phase <= ~phase;
                end
            end
        end
    end

endmodule

// File: rtl/multi_deck_player_control.sv
// Multi-deck beat-position controller: NUM_DECKS independent deck channels on packed buses.
module multi_deck_player_control
    import deck_pkg::*;
#(
    parameter int unsigned NUM_DECKS = 2,
    parameter int unsigned LEN       = 6250000,
    parameter int unsigned W         = 26
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_DECKS-1:0]   play_req,
    input  logic [NUM_DECKS-1:0]   pause_req,
    input  logic [NUM_DECKS-1:0]   stop_req,
    input  logic [NUM_DECKS-1:0]   mode,
    input  logic [2*NUM_DECKS-1:0] rate,
    input  logic [W*NUM_DECKS-1:0] loop_start,
    input  logic [W*NUM_DECKS-1:0] loop_end,
    input  logic [NUM_DECKS-1:0]   seek_valid,
    input  logic [W*NUM_DECKS-1:0] seek_pos,
    output logic [W*NUM_DECKS-1:0] ibeat,
    output logic [2*NUM_DECKS-1:0] deck_state,
    output logic [NUM_DECKS-1:0]   wrap_pulse
);

    for (genvar d = 0; d < NUM_DECKS; d++) begin : g_deck
        deck_channel #(
            .LEN (LEN),
            .W   (W)
        ) u_deck (
            .clk        (clk),
            .reset      (reset),
            .play_req   (play_req[d]),
            .pause_req  (pause_req[d]),
            .stop_req   (stop_req[d]),
            .mode       (mode[d]),
            .rate       (rate[2*d +: 2]),
            .loop_start (loop_start[W*d +: W]),
            .loop_end   (loop_end[W*d +: W]),
            .seek_valid (seek_valid[d]),
            .seek_pos   (seek_pos[W*d +: W]),
            .ibeat      (ibeat[W*d +: W]),
            .deck_state (deck_state[2*d +: 2]),
            .wrap_pulse (wrap_pulse[d])
        );
    end

endmodule
